nibble_serial_adder: RTL
========================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16: operand width in bits; an integer multiple of 4, minimum 8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1: operand set A/B/Cin is offered.
REQ-005 The block SHALL have port in_ready, output, 1: block can accept operands this cycle.
REQ-006 The block SHALL have port A, input, WORD_W: first operand.
REQ-007 The block SHALL have port B, input, WORD_W: second operand.
REQ-008 The block SHALL have port Cin, input, 1: carry into bit 0.
REQ-009 The block SHALL have port out_valid, output, 1: result on Sum/Cout/Ovf is valid.
REQ-010 The block SHALL have port out_ready, input, 1: consumer accepts the result this cycle.
REQ-011 The block SHALL have port Sum, output, WORD_W: A+B+Cin modulo 2^WORD_W.
REQ-012 The block SHALL have port Cout, output, 1: carry out of bit WORD_W-1.
REQ-013 The block SHALL have port Ovf, output, 1: two's-complement overflow, defined as carry into MSB XOR Cout.
REQ-014 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, ADD, DONE.
REQ-016 The block SHALL define an input handshake as in_valid=1 AND in_ready=1 at a rising edge.
- in_ready SHALL be 1 only in IDLE.
- On the handshake the block SHALL register A, B and Cin, clear nibble index k to 0, load the carry register with Cin, and go to ADD.
REQ-017 In ADD, each cycle the block SHALL add nibble k (bits 4k+3..4k) of the registered operands using 4-bit carry-lookahead.
- Per-bit P=A^B and G=A&B.
- C1..C3 and the nibble carry-out SHALL be computed as two-level sum-of-products from G, P and the registered carry, with no ripple chain.
REQ-018 Each ADD cycle the block SHALL write the nibble sum into Sum bits 4k+3..4k, load the carry register with the nibble carry-out, and increment k.
REQ-019 When k = WORD_W/4-1 in ADD, the block SHALL also register Cout and Ovf (C3 of that nibble XOR its carry-out), then go to DONE.
REQ-020 Latency: with the handshake at edge T, out_valid SHALL rise after edge T+WORD_W/4 (after edge T+4 for the default width).
REQ-021 In DONE, out_valid SHALL be 1, and Sum/Cout/Ovf SHALL be held stable until out_ready=1 at a rising edge; the block SHALL then go to IDLE.
REQ-022 Sum, Cout and Ovf SHALL keep their last values after leaving DONE; they are meaningful only while out_valid=1.
REQ-023 Changes on A, B, Cin or in_valid outside the IDLE handshake SHALL have no effect.
REQ-024 The block SHALL accept no new operand in DONE, even when out_ready=1 in the same cycle; the earliest next handshake is the cycle after returning to IDLE.
- Peak throughput: one result per WORD_W/4+2 cycles.
REQ-025 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-026 With rst=1 at a rising edge, the FSM SHALL go to IDLE and k and the carry register SHALL be cleared.
- Sum=0, Cout=0, Ovf=0, out_valid=0, busy=0.
- in_ready SHALL be 1 from the following cycle.
REQ-027 rst SHALL take priority over every other input.
- A reset in ADD or DONE SHALL discard the in-flight operation and produce no out_valid for it.
- A handshake coincident with rst SHALL not be accepted.

Verification
REQ-028 A bench SHALL drive A=0xFFFF, B=0x0001, Cin=0 and check Sum=0x0000, Cout=1, Ovf=0, with out_valid rising 4 cycles after the handshake.
REQ-029 A bench SHALL drive A=0x7FFF, B=0x0001, Cin=0 and check Sum=0x8000, Cout=0, Ovf=1.
- It SHALL also drive A=0x8000, B=0x8000, Cin=1 and check Sum=0x0001, Cout=1, Ovf=1.
REQ-030 A bench SHALL drive A=0x1234, B=0x4321, Cin=1 and check Sum=0x5556, Cout=0, Ovf=0.
- The bench SHALL change A/B every cycle during ADD and check the result is unaffected.
REQ-031 A bench SHALL apply backpressure: out_ready=0 for 5 cycles in DONE.
- out_valid and Sum SHALL stay stable and in_ready SHALL stay 0.
- After out_ready=1, the block SHALL be in IDLE with in_ready=1 on the next cycle.
REQ-032 A bench SHALL assert rst at the second ADD cycle and check that out_valid never rises for that operation.
- All outputs SHALL be zero and in_ready=1 afterwards.
- A following 0x0F0F+0x00F1 SHALL give Sum=0x1000, Cout=0.
REQ-033 A bench SHALL run back-to-back operations with in_valid held high and out_ready=1.
- One result SHALL occur every 6 cycles.
- 1000 random operands SHALL match a reference model for WORD_W=16 and WORD_W=8.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two WORD_W-bit operands one nibble per cycle with a 4-bit carry-lookahead slice.
module nibble_serial_adder #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              Cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] Sum,
  output logic              Cout,
  output logic              Ovf,
  output logic              busy
);
  localparam int NIB = WORD_W / 4;
  localparam int KW = $clog2(NIB);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);
  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_a, r_b, r_sum;
  logic [KW-1:0]     r_k;
  logic              r_c, r_cout, r_ovf;
  logic [3:0]        w_p, w_g, w_s;
  logic [4:0]        w_c;
  // Two-level lookahead: every carry comes straight from G/P and the registered carry.
  always_comb begin
    w_p = r_a[{r_k, 2'b00} +: 4] ^ r_b[{r_k, 2'b00} +: 4];
    w_g = r_a[{r_k, 2'b00} +: 4] & r_b[{r_k, 2'b00} +: 4];
    w_c[0] = r_c;
    w_c[1] = w_g[0] | (w_p[0] & r_c);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_c);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) | (w_p[2] & w_p[1] & w_p[0] & r_c);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_c);
    w_s = w_p ^ w_c[3:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_a     <= A;
        r_b     <= B;
        r_c     <= Cin;
        r_k     <= '0;
        r_state <= ADD;
      end
    end else if (r_state == ADD) begin
      r_sum[{r_k, 2'b00} +: 4] <= w_s;
      r_c <= w_c[4];
      r_k <= r_k + 1'b1;
      if (r_k == K_LAST) begin
        r_cout  <= w_c[4];
        r_ovf   <= w_c[3] ^ w_c[4];
        r_state <= DONE;
      end
    end else if (out_ready) begin
      r_state <= IDLE;
    end
  end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Ovf       = r_ovf;
endmodule
